// File: rtl/axi_s_pkg.sv
// -----------------------------------------------------------------------------
// axi_s_pkg
// Shared constants and helpers for the AXI4-Stream FIFO.
//   - Default parameter values for the stream field widths and FIFO depth.
//   - payload_width(): width of the packed beat stored in the FIFO memory,
//     laid out as {TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER}.
// -----------------------------------------------------------------------------
package axi_s_pkg;

    localparam int TDATA_WIDTH_DEF = 8;
    localparam int TID_WIDTH_DEF   = 1;
    localparam int TDEST_WIDTH_DEF = 1;
    localparam int TUSER_WIDTH_DEF = 1;
    localparam int DEPTH_DEF       = 16;

    // TKEEP and TSTRB each carry one bit per data byte; TLAST is one bit.
    function automatic int payload_width(input int tdata_w,
                                         input int tid_w,
                                         input int tdest_w,
                                         input int tuser_w);
        return tdata_w + 2 * (tdata_w / 8) + 1 + tid_w + tdest_w + tuser_w;
    endfunction

endpackage

// File: rtl/axi_s_fifo_mem.sv
// -----------------------------------------------------------------------------
// axi_s_fifo_mem
// DEPTH x W storage array for the FIFO: synchronous write, asynchronous read.
// The asynchronous read is what gives the FIFO its first-word-fall-through
// output. Contents are deliberately not reset.
// Ports:
//   i_clk      write clock
//   i_wr_en    write strobe (one entry per cycle)
//   i_wr_addr  write address
//   i_wr_data  packed beat to store
//   i_rd_addr  read address
//   o_rd_data  packed beat at i_rd_addr (combinational)
// -----------------------------------------------------------------------------
module axi_s_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 14
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axi_s_fifo.sv
// -----------------------------------------------------------------------------
// axi_s_fifo
// Single-clock AXI4-Stream FIFO. Buffers complete beats (TDATA, TKEEP, TSTRB,
// TLAST, TID, TDEST, TUSER) in order, decouples backpressure, and reports how
// many beats and how many complete packets (TLAST beats) it holds.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   s_T*                   upstream AXI-Stream slave port
//   m_T*                   downstream AXI-Stream master port (FWFT)
//   level                  number of beats stored (0..DEPTH)
//   pkt_count              number of stored beats with TLAST=1
// -----------------------------------------------------------------------------
module axi_s_fifo
    import axi_s_pkg::*;
#(
    parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
    parameter int TID_WIDTH   = TID_WIDTH_DEF,
    parameter int TDEST_WIDTH = TDEST_WIDTH_DEF,
    parameter int TUSER_WIDTH = TUSER_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,

    input  logic                       s_TVALID,
    output logic                       s_TREADY,
    input  logic [TDATA_WIDTH-1:0]     s_TDATA,
    input  logic [TDATA_WIDTH/8-1:0]   s_TKEEP,
    input  logic [TDATA_WIDTH/8-1:0]   s_TSTRB,
    input  logic                       s_TLAST,
    input  logic [TID_WIDTH-1:0]       s_TID,
    input  logic [TDEST_WIDTH-1:0]     s_TDEST,
    input  logic [TUSER_WIDTH-1:0]     s_TUSER,

    output logic                       m_TVALID,
    input  logic                       m_TREADY,
    output logic [TDATA_WIDTH-1:0]     m_TDATA,
    output logic [TDATA_WIDTH/8-1:0]   m_TKEEP,
    output logic [TDATA_WIDTH/8-1:0]   m_TSTRB,
    output logic                       m_TLAST,
    output logic [TID_WIDTH-1:0]       m_TID,
    output logic [TDEST_WIDTH-1:0]     m_TDEST,
    output logic [TUSER_WIDTH-1:0]     m_TUSER,

    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = payload_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] r_pkt_count;
    logic          r_s_tready;

    logic [LW-1:0] w_level_next;
    logic [LW-1:0] w_pkt_next;
    logic          w_push;
    logic          w_pop;
    logic          w_m_tvalid;
    logic [PW-1:0] w_wr_data;
    logic [PW-1:0] w_rd_data;

    // r_s_tready is only ever 1 while level < DEPTH, so a push can never land
    // on a full FIFO, even when a pop happens on the same edge.
    assign w_m_tvalid = (r_level != '0);
    assign w_push     = s_TVALID && r_s_tready;
    assign w_pop      = w_m_tvalid && m_TREADY;

    assign w_wr_data = {s_TDATA, s_TKEEP, s_TSTRB, s_TLAST, s_TID, s_TDEST, s_TUSER};
    assign {m_TDATA, m_TKEEP, m_TSTRB, m_TLAST, m_TID, m_TDEST, m_TUSER} = w_rd_data;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LW'(1);
        end
        // Push and pop of TLAST beats on the same edge cancel out.
        w_pkt_next = r_pkt_count + LW'(w_push && s_TLAST) - LW'(w_pop && m_TLAST);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pkt_count <= '0;
            r_s_tready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level     <= w_level_next;
            r_pkt_count <= w_pkt_next;
            // Registered ready: no combinational path from m_TREADY. A pop from
            // full therefore costs one input bubble.
            r_s_tready  <= (w_level_next < LW'(DEPTH));
        end
    end

    axi_s_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_mem (
        .i_clk     (ACLK),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign s_TREADY  = r_s_tready;
    assign m_TVALID  = w_m_tvalid;
    assign level     = r_level;
    assign pkt_count = r_pkt_count;

endmodule
